// File: rtl/fpcif_pkg.sv
// Shared definitions for the fpcif integer-to-single converter.
//   state_e  : FSM state encoding (capture, normalise, round, done)
//   FLG_*    : bit indices into the 5-bit exception flag vector
//   EXP_TOP  : biased exponent of 2^31 (bias 127 + 31), the starting exponent
package fpcif_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StNorm  = 2'd1,
    StRound = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned FLG_V = 4;  // invalid
  localparam int unsigned FLG_Z = 3;  // divide by zero
  localparam int unsigned FLG_O = 2;  // overflow
  localparam int unsigned FLG_U = 1;  // underflow
  localparam int unsigned FLG_X = 0;  // inexact

  localparam logic [7:0] EXP_TOP = 8'd158;

endpackage

// File: rtl/fpcif_rnd.sv
// Round-to-nearest-even stage of the converter (purely combinational).
//   m       : normalised magnitude, m[31] = 1 (hidden bit)
//   e       : biased exponent matching m
//   sign    : result sign
//   z       : packed IEEE-754 single result
//   inexact : set when any discarded bit (guard or sticky) is non-zero
module fpcif_rnd
  import fpcif_pkg::*;
(
  input  logic [31:0] m,
  input  logic [7:0]  e,
  input  logic        sign,
  output logic [31:0] z,
  output logic        inexact
);

  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [30:0] sum;
  logic        unused_hidden;

  assign lsb    = m[8];
  assign guard  = m[7];
  assign sticky = |m[6:0];
  assign inc    = guard & (sticky | lsb);

  // Adding across {e, frac} lets a fraction carry-out bump the exponent
  // while the fraction wraps to zero.
  assign sum = {e, m[30:8]} + {30'd0, inc};

  assign z       = {sign, sum};
  assign inexact = guard | sticky;

  // Hidden bit is implied by normalisation.
  assign unused_hidden = m[31];

endmodule

// File: rtl/fpcif_seq.sv
// Multi-cycle int32/uint32 to IEEE-754 single converter with run/stall handshake.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   run   : request, held until stall is seen low, then dropped
//   stall : run & (state != done); first low cycle has z/flags valid
//   x     : integer operand, sampled only in the capture cycle
//   z     : registered single-precision result
//   flags : registered exception flags {invalid, div0, overflow, underflow, inexact}
module fpcif_seq
  import fpcif_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        stall,
  input  logic [31:0] x,
  output logic [31:0] z,
  output logic [4:0]  flags
);

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [7:0]  e_q, e_d;
  logic        sign_q, sign_d;
  logic [31:0] z_q, z_d;
  logic [4:0]  flags_q, flags_d;

  logic        sign_in;
  logic [31:0] mag_in;
  logic [31:0] rnd_z;
  logic        rnd_inexact;

  // 0x80000000 negates to itself, which is the correct magnitude.
  assign sign_in = SIGNED & x[31];
  assign mag_in  = sign_in ? (~x + 32'd1) : x;

  fpcif_rnd u_rnd (
    .m       (m_q),
    .e       (e_q),
    .sign    (sign_q),
    .z       (rnd_z),
    .inexact (rnd_inexact)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    sign_d  = sign_q;
    z_d     = z_q;
    flags_d = flags_q;

    case (state_q)
      StIdle: begin
        if (run) begin
          sign_d = sign_in;
          m_d    = mag_in;
          e_d    = EXP_TOP;
          if (mag_in == 32'd0) begin
            z_d     = 32'd0;
            flags_d = 5'd0;
            state_d = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (!run) begin
          state_d = StIdle;
        end else if (m_q[31]) begin
          state_d = StRound;
        end else begin
          m_d = {m_q[30:0], 1'b0};
          e_d = e_q - 8'd1;
        end
      end
      StRound: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          z_d            = rnd_z;
          flags_d        = 5'd0;
          flags_d[FLG_X] = rnd_inexact;
          state_d        = StDone;
        end
      end
      StDone: begin
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= 32'd0;
      e_q     <= 8'd0;
      sign_q  <= 1'b0;
      z_q     <= 32'd0;
      flags_q <= 5'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  assign stall = run & (state_q != StDone);
  assign z     = z_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fpcif_seq.sv
// Self-checking bench for fpcif_seq: a signed and an unsigned instance share
// run/x; a driver pushes reference results into per-instance queues and a
// negedge monitor pops and compares when each instance releases stall.
module tb_fpcif_seq;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  flags;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] x = 32'd0;
  logic        stall_s, stall_u;
  logic [31:0] z_s, z_u;
  logic [4:0]  f_s, f_u;

  exp_t q_s[$];
  exp_t q_u[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt[2];
  bit   done[2];
  logic [31:0] last_z[2];
  logic [4:0]  last_f[2];

  always #10 clk = ~clk;

  fpcif_seq #(.SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .stall (stall_s),
    .x     (x),
    .z     (z_s),
    .flags (f_s)
  );

  fpcif_seq #(.SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .stall (stall_u),
    .x     (x),
    .z     (z_u),
    .flags (f_u)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: float value of the integer via msb position and remainder RNE.
  function automatic exp_t model(input logic [31:0] xv, input bit sgn);
    exp_t r;
    longint unsigned mag, q, rem, half;
    int p, sh;
    bit neg;
    neg  = sgn && xv[31];
    mag  = neg ? (64'h1_0000_0000 - {32'd0, xv}) : {32'd0, xv};
    r    = '0;
    r.lat = 8'd1;
    if (mag == 0) return r;
    p = 31;
    while (mag[p] == 1'b0) p--;
    r.lat = 8'(34 - p);
    if (p <= 23) begin
      q   = mag << (23 - p);
      rem = 0;
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    r.z     = {neg, 8'(p + 127), q[22:0]};
    r.flags = {4'b0000, rem != 0};
    return r;
  endfunction

  task automatic mon_step(input int i, input logic st, input logic [31:0] zz,
                          input logic [4:0] ff);
    exp_t e;
    string tag;
    tag = (i == 0) ? "signed" : "unsigned";
    if (!rst_n) begin
      cnt[i]    = 0;
      done[i]   = 1'b0;
      last_z[i] = 32'd0;
      last_f[i] = 5'd0;
    end else if (!run) begin
      cnt[i]  = 0;
      done[i] = 1'b0;
      chk({tag, " hold_z"}, zz, last_z[i]);
      chk({tag, " hold_flags"}, 32'(ff), 32'(last_f[i]));
    end else if (!done[i]) begin
      if (st) begin
        cnt[i]++;
      end else begin
        done[i] = 1'b1;
        if ((i == 0 && q_s.size() == 0) || (i == 1 && q_u.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_result actual=%h required=none", tag, zz);
        end else begin
          e = (i == 0) ? q_s.pop_front() : q_u.pop_front();
          chk({tag, " z"}, zz, e.z);
          chk({tag, " flags"}, 32'(ff), 32'(e.flags));
          chk({tag, " latency"}, 32'(cnt[i]), 32'(e.lat));
          last_z[i] = e.z;
          last_f[i] = e.flags;
        end
      end
    end else begin
      chk({tag, " done_stall"}, 32'(st), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step(0, stall_s, z_s, f_s);
      mon_step(1, stall_u, z_u, f_u);
    end
  end

  task automatic do_op(input logic [31:0] xv, input int hold);
    int n;
    q_s.push_back(model(xv, 1'b1));
    q_u.push_back(model(xv, 1'b0));
    @(posedge clk);
    #1;
    x   = xv;
    run = 1'b1;
    n   = 0;
    @(negedge clk);
    #1;
    while (!(done[0] && done[1]) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout x=%h actual=stall_high required=stall_low", xv);
      q_s.delete();
      q_u.delete();
    end
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    run = 1'b0;
    x   = $urandom;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xv;
    repeat (3) @(posedge clk);
    #1;
    chk("reset z_s", z_s, 32'd0);
    chk("reset flags_u", 32'(f_u), 32'd0);
    chk("reset stall_s", 32'(stall_s), 32'(run));
    rst_n = 1'b1;

    do_op(32'h0000_0001, 0);
    do_op(32'hFFFF_FFFF, 1);
    do_op(32'h7FFF_FFFF, 0);
    do_op(32'h8000_0000, 2);
    do_op(32'h0100_0001, 0);
    do_op(32'h0100_0003, 0);
    do_op(32'h0000_0000, 5);
    do_op(32'h0123_4567, 0);

    // Abort during normalisation: z/flags must hold, next op must start clean.
    @(posedge clk);
    #1;
    x   = 32'h0000_0010;
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run = 1'b0;
    x   = $urandom;
    do_op(32'h0000_0010, 0);
    do_op(32'h7FFF_FFFF, 0);

    // Asynchronous reset mid-normalisation.
    @(posedge clk);
    #1;
    x   = 32'h0000_0010;
    run = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async z_s", z_s, 32'd0);
    chk("async z_u", z_u, 32'd0);
    chk("async flags_s", 32'(f_s), 32'd0);
    chk("async flags_u", 32'(f_u), 32'd0);
    chk("async stall_s", 32'(stall_s), 32'(run));
    chk("async stall_u", 32'(stall_u), 32'(run));
    run = 1'b0;
    #1;
    chk("async stall_s low", 32'(stall_s), 32'(run));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      xv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) xv = -xv;
      do_op(xv, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    chk("queues empty", 32'(q_s.size() + q_u.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
